// File: rtl/rowwise_multiop_unit_if.sv
// Handshake and operand/result bundle for rowwise_multiop_unit.
// The master side drives operands and the handshake inputs; the slave side is the unit.
interface rowwise_multiop_unit_if #(
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned DATA_W  = 16
);
    logic [VEC_LEN*DATA_W-1:0] a_i;
    logic [VEC_LEN*DATA_W-1:0] b_i;
    logic [2:0]                op_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [VEC_LEN*DATA_W-1:0] vector_o;
    logic                      sat_o;
    logic                      err_o;
    logic                      out_valid_o;
    logic                      out_ready_i;

    modport master (
        output a_i, b_i, op_i, in_valid_i, out_ready_i,
        input  in_ready_o, vector_o, sat_o, err_o, out_valid_o
    );

    modport slave (
        input  a_i, b_i, op_i, in_valid_i, out_ready_i,
        output in_ready_o, vector_o, sat_o, err_o, out_valid_o
    );
endinterface

// File: rtl/rowwise_multiop_unit.sv
// Element-wise saturating ADD/SUB/MUL(Q-format)/MAX/MIN over a packed vector,
// LANES elements per cycle, with a latched-operand IDLE/BUSY/DONE handshake.
module rowwise_multiop_unit #(
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LANES   = 4,
    parameter int unsigned FRAC_W  = 8
) (
    input logic                   clk_i,
    input logic                   rst_i,
    rowwise_multiop_unit_if.slave bus
);
    localparam int unsigned W      = VEC_LEN * DATA_W;
    localparam int unsigned WIDE_W = 2 * DATA_W;
    localparam int unsigned BEATS  = VEC_LEN / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    if (LANES == 0 || (VEC_LEN % LANES) != 0) begin : g_bad_lanes
        $fatal(1, "rowwise_multiop_unit: VEC_LEN must be a non-zero multiple of LANES");
    end
    if (FRAC_W >= DATA_W) begin : g_bad_frac
        $fatal(1, "rowwise_multiop_unit: FRAC_W must be below DATA_W");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2,
                              OP_MAX = 3'd3, OP_MIN = 3'd4} op_e;

    typedef struct packed {
        logic              sat;
        logic [DATA_W-1:0] val;
    } lane_t;

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [W-1:0]       res_q, res_d;
    logic               sat_q, sat_d;
    logic               err_q, err_d;
    logic [31:0]        beat_base;

    // Full-precision result in 2*DATA_W, then clamp; illegal ops fall through as zero.
    function automatic lane_t lane_calc(input logic signed [DATA_W-1:0] a,
                                        input logic signed [DATA_W-1:0] b,
                                        input logic [2:0]               op);
        logic signed [WIDE_W-1:0] ea;
        logic signed [WIDE_W-1:0] eb;
        logic signed [WIDE_W-1:0] wide;
        lane_t                    r;
        ea   = WIDE_W'(a);
        eb   = WIDE_W'(b);
        wide = '0;
        r    = '0;
        case (op)
            OP_ADD:  wide = ea + eb;
            OP_SUB:  wide = ea - eb;
            OP_MUL:  wide = (ea * eb) >>> FRAC_W;
            OP_MAX:  wide = (ea > eb) ? ea : eb;
            OP_MIN:  wide = (ea < eb) ? ea : eb;
            default: wide = '0;
        endcase
        if (wide > SAT_MAX) begin
            r.sat = 1'b1;
            r.val = SAT_MAX[DATA_W-1:0];
        end else if (wide < SAT_MIN) begin
            r.sat = 1'b1;
            r.val = SAT_MIN[DATA_W-1:0];
        end else begin
            r.val = wide[DATA_W-1:0];
        end
        return r;
    endfunction

    assign beat_base = 32'(beat_q) * LANES;

    always_comb begin
        lane_t lr;
        state_d = state_q;
        beat_d  = beat_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        sat_d   = sat_q;
        err_d   = err_q;
        lr      = '0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    op_d    = bus.op_i;
                    beat_d  = '0;
                    sat_d   = 1'b0;
                    err_d   = (bus.op_i > OP_MIN);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    lr = lane_calc(a_q[(beat_base + l) * DATA_W +: DATA_W],
                                   b_q[(beat_base + l) * DATA_W +: DATA_W], op_q);
                    res_d[(beat_base + l) * DATA_W +: DATA_W] = lr.val;
                    sat_d = sat_d | lr.sat;
                end
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.vector_o    = res_q;
    assign bus.sat_o       = sat_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_rowwise_multiop_unit.sv
// Directed bench for rowwise_multiop_unit: three instances (LANES = 4, 1, 16)
// share operands; handshakes are per instance.
module tb_rowwise_multiop_unit;
    localparam int unsigned VL = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned W  = VL * DW;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [2:0]   op  = '0;
    logic         iv   [3];
    logic         ordy [3];
    logic [W-1:0] vec  [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         sat  [3];
    logic         err  [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rowwise_multiop_unit_if #(.VEC_LEN(VL), .DATA_W(DW)) u_if ();
        rowwise_multiop_unit #(
            .VEC_LEN(VL), .DATA_W(DW),
            .LANES((g == 0) ? 4 : ((g == 1) ? 1 : 16)),
            .FRAC_W(8)
        ) u_dut (
            .clk_i(clk),
            .rst_i(rst),
            .bus  (u_if)
        );
        assign u_if.a_i        = a;
        assign u_if.b_i        = b;
        assign u_if.op_i       = op;
        assign u_if.in_valid_i = iv[g];
        assign u_if.out_ready_i = ordy[g];
        assign vec[g] = u_if.vector_o;
        assign ir[g]  = u_if.in_ready_o;
        assign ov[g]  = u_if.out_valid_o;
        assign sat[g] = u_if.sat_o;
        assign err[g] = u_if.err_o;
    end

    function automatic logic [W-1:0] fill(input logic [DW-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < VL; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] one(input int k, input logic [DW-1:0] v);
        logic [W-1:0] r;
        r = '0;
        r[k*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] ramp(input int mul, input int off);
        logic [W-1:0] r;
        for (int k = 0; k < VL; k++) r[k*DW +: DW] = DW'(k * mul + off);
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operands are scrambled right after the accept edge so a result that
    // depends on live inputs shows up as a wrong vector.
    task automatic start(input int i, input logic [2:0] o, input logic [W-1:0] va,
                         input logic [W-1:0] vb);
        a = va; b = vb; op = o; iv[i] = 1'b1;
        tick();
        iv[i] = 1'b0; a = '1; b = {W/2{2'b10}}; op = 3'd6;
        check("accepted", W'(ir[i]), W'(0));
    endtask

    task automatic wait_done(input int i, input int beats, input string tag);
        int cycles;
        cycles = 0;
        while (ov[i] !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        check({tag, " latency"}, W'(cycles), W'(beats));
    endtask

    task automatic finish_out(input int i, input string tag);
        ordy[i] = 1'b1;
        tick();
        ordy[i] = 1'b0;
        check({tag, " out_valid drop"}, W'(ov[i]), W'(0));
        check({tag, " in_ready back"}, W'(ir[i]), W'(1));
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] exp_v;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b0;
        end

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst in_ready", W'(ir[i]), W'(1));
            check("rst out_valid", W'(ov[i]), W'(0));
            check("rst vector", vec[i], '0);
            check("rst sat", W'(sat[i]), W'(0));
            check("rst err", W'(err[i]), W'(0));
        end

        // ADD 100 + -30 with out_ready held high
        ordy[0] = 1'b1;
        start(0, 3'd0, fill(16'd100), fill(16'hFFE2));
        wait_done(0, 4, "add");
        check("add vector", vec[0], fill(16'd70));
        check("add sat", W'(sat[0]), W'(0));
        check("add err", W'(err[0]), W'(0));
        tick();
        ordy[0] = 1'b0;
        check("add handshake done", W'(ov[0]), W'(0));
        check("add in_ready", W'(ir[0]), W'(1));

        start(0, 3'd0, one(5, 16'h7FFF), one(5, 16'h0001));
        wait_done(0, 4, "add sat");
        check("add sat vector", vec[0], one(5, 16'h7FFF));
        check("add sat flag", W'(sat[0]), W'(1));
        finish_out(0, "add sat");

        start(0, 3'd1, one(5, 16'h8000), one(5, 16'h0001));
        wait_done(0, 4, "sub sat");
        check("sub sat vector", vec[0], one(5, 16'h8000));
        check("sub sat flag", W'(sat[0]), W'(1));
        finish_out(0, "sub sat");

        start(0, 3'd2, fill(16'h0180), fill(16'hFF00));
        wait_done(0, 4, "mul");
        check("mul vector", vec[0], fill(16'hFE80));
        check("mul sat", W'(sat[0]), W'(0));
        finish_out(0, "mul");

        start(0, 3'd2, one(9, 16'h7F00), one(9, 16'h7F00));
        wait_done(0, 4, "mul sat");
        check("mul sat vector", vec[0], one(9, 16'h7FFF));
        check("mul sat flag", W'(sat[0]), W'(1));
        finish_out(0, "mul sat");

        // -1/256 * 0.5 floors to -1/256
        start(0, 3'd2, fill(16'hFFFF), fill(16'h0080));
        wait_done(0, 4, "mul floor");
        check("mul floor vector", vec[0], fill(16'hFFFF));
        finish_out(0, "mul floor");

        start(0, 3'd3, fill(16'hFFFB), fill(16'd3));
        wait_done(0, 4, "max");
        check("max vector", vec[0], fill(16'd3));
        check("max sat", W'(sat[0]), W'(0));
        finish_out(0, "max");

        start(0, 3'd4, fill(16'hFFFB), fill(16'd3));
        wait_done(0, 4, "min");
        check("min vector", vec[0], fill(16'hFFFB));
        finish_out(0, "min");

        // element k: a = k-8, b = 0
        for (int k = 0; k < VL; k++) exp_v[k*DW +: DW] = (k >= 8) ? DW'(k - 8) : '0;
        start(0, 3'd3, ramp(1, -8), '0);
        wait_done(0, 4, "max ramp");
        check("max ramp vector", vec[0], exp_v);
        finish_out(0, "max ramp");

        for (int k = 0; k < VL; k++) exp_v[k*DW +: DW] = (k < 8) ? DW'(k - 8) : '0;
        start(0, 3'd4, ramp(1, -8), '0);
        wait_done(0, 4, "min ramp");
        check("min ramp vector", vec[0], exp_v);
        finish_out(0, "min ramp");

        start(0, 3'd6, fill(16'd100), fill(16'd5));
        wait_done(0, 4, "illegal");
        check("illegal vector", vec[0], '0);
        check("illegal err", W'(err[0]), W'(1));
        check("illegal sat", W'(sat[0]), W'(0));
        finish_out(0, "illegal");

        // backpressure: DONE held 10 cycles with inputs churning
        start(0, 3'd0, fill(16'd1), fill(16'd2));
        wait_done(0, 4, "bp");
        check("bp err cleared", W'(err[0]), W'(0));
        held = fill(16'd3);
        iv[0] = 1'b1;
        a = fill(16'd9); op = 3'd0;
        for (int c = 0; c < 10; c++) begin
            a = ~a;
            tick();
            check("bp vector stable", vec[0], held);
            check("bp in_ready low", W'(ir[0]), W'(0));
            check("bp out_valid high", W'(ov[0]), W'(1));
        end
        a = fill(16'd10); b = fill(16'd20); op = 3'd0; ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        check("bp released", W'(ov[0]), W'(0));
        check("bp idle", W'(ir[0]), W'(1));
        tick();
        iv[0] = 1'b0; a = '1; b = '1; op = 3'd6;
        check("bp second accepted", W'(ir[0]), W'(0));
        wait_done(0, 4, "bp second");
        check("bp second vector", vec[0], fill(16'd30));
        finish_out(0, "bp second");

        // reset in DONE, held two edges with in_valid high: no accept, no handshake
        start(0, 3'd0, fill(16'd4), fill(16'd4));
        wait_done(0, 4, "rst done");
        rst = 1'b1; ordy[0] = 1'b1; iv[0] = 1'b1;
        tick(); tick();
        rst = 1'b0; ordy[0] = 1'b0; iv[0] = 1'b0;
        check("rst done idle", W'(ir[0]), W'(1));
        check("rst done out_valid", W'(ov[0]), W'(0));
        check("rst done vector", vec[0], '0);

        // reset during BUSY (beat 2, or last beat when fewer) on each lane width
        for (int i = 0; i < 3; i++) begin
            int beats;
            int pre;
            beats = (i == 0) ? 4 : ((i == 1) ? 16 : 1);
            pre = (beats > 2) ? 2 : beats - 1;
            start(i, 3'd0, fill(16'd7), fill(16'd8));
            for (int c = 0; c < pre; c++) tick();
            check("abort still busy", W'(ov[i]), W'(0));
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("abort idle", W'(ir[i]), W'(1));
            check("abort out_valid", W'(ov[i]), W'(0));
            check("abort vector", vec[i], '0);
            check("abort sat", W'(sat[i]), W'(0));
            start(i, 3'd1, ramp(3, 0), ramp(1, 0));
            wait_done(i, beats, "after abort");
            check("after abort vector", vec[i], ramp(2, 0));
            check("after abort sat", W'(sat[i]), W'(0));
            finish_out(i, "after abort");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
